uart_tx: RTL and testbench

- Serialiser counterpart to the UART receive path. Converts a parallel byte into an asynchronous serial frame on a single line: start bit, data bits LSB first, optional parity bit, one stop bit.
- Runs on the system clock at the same oversampling Prescale as the receiver. Each serial bit is held for exactly Prescale clocks.
- A link built from this transmitter and the receiver uses identical Prescale, Parity_En and Parity_Typ settings.

---
 rtl/uart_tx.sv | 117 +++++++++++
 tb/tb_uart_tx.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx -- asynchronous serial transmitter.
//
// Sends one frame per accepted request: start bit (0), `width` data bits
// LSB first, an optional parity bit, then one stop bit (1). Every bit is
// held on TX_OUT for exactly P clocks, where P is the Prescale value latched
// at acceptance (0 and 1 both mean one clock per bit).
//
// Ports:
//   Clk         system clock, rising edge
//   Rst         synchronous reset, active low
//   P_Data      parallel data, latched on acceptance
//   Data_Valid  request; accepted only while idle
//   Prescale    clocks per serial bit, latched on acceptance
//   Parity_En   1 = append a parity bit, latched on acceptance
//   Parity_Typ  0 = even, 1 = odd, latched on acceptance
//   TX_OUT      registered serial line, idles high
//   Busy        registered, high for the whole frame
module uart_tx #(
    parameter int width = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [width-1:0] P_Data,
    input  logic             Data_Valid,
    input  logic [5:0]       Prescale,
    input  logic             Parity_En,
    input  logic             Parity_Typ,
    output logic             TX_OUT,
    output logic             Busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [4:0] LAST_BIT = 5'(width - 1);

    state_t           state;
    logic [width-1:0] shreg;     // remaining data; bit 0 is the bit on the line
    logic [5:0]       p_last;    // latched P-1, the edge counter's wrap value
    logic [5:0]       edge_cnt;
    logic [4:0]       bit_cnt;
    logic             par_en;
    logic             par_bit;

    logic             bit_end;
    logic [width-1:0] sh_next;

    assign bit_end = (edge_cnt == p_last);
    assign sh_next = shreg >> 1;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state    <= IDLE;
            shreg    <= '0;
            p_last   <= '0;
            edge_cnt <= '0;
            bit_cnt  <= '0;
            par_en   <= 1'b0;
            par_bit  <= 1'b0;
            TX_OUT   <= 1'b1;
            Busy     <= 1'b0;
        end else if (state == IDLE) begin
            if (Data_Valid) begin
                shreg    <= P_Data;
                // Prescale of 0 or 1 both give a one-clock bit.
                p_last   <= (Prescale < 6'd2) ? 6'd0 : Prescale - 6'd1;
                par_en   <= Parity_En;
                // Odd parity is the inverted XOR, so XOR in the type bit.
                par_bit  <= (^P_Data) ^ Parity_Typ;
                edge_cnt <= '0;
                bit_cnt  <= '0;
                state    <= START;
                TX_OUT   <= 1'b0;
                Busy     <= 1'b1;
            end
        end else if (bit_end) begin
            // Bit boundary: the only place TX_OUT is allowed to change.
            edge_cnt <= '0;
            case (state)
                START: begin
                    state  <= DATA;
                    TX_OUT <= shreg[0];
                end
                DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        if (par_en) begin
                            state  <= PARITY;
                            TX_OUT <= par_bit;
                        end else begin
                            state  <= STOP;
                            TX_OUT <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                        shreg   <= sh_next;
                        TX_OUT  <= sh_next[0];
                    end
                end
                PARITY: begin
                    state  <= STOP;
                    TX_OUT <= 1'b1;
                end
                STOP: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b0;
                end
            endcase
        end else begin
            edge_cnt <= edge_cnt + 6'd1;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- self-checking bench for uart_tx (width = 8).
//
// Each request pushes the expected bit sequence, frame length and effective
// P into scoreboard queues; check_frame pops them and compares TX_OUT and
// Busy on every cycle of the frame. The loopback test decodes the line with
// a mid-bit sampling receiver model and compares against a byte scoreboard.
module tb_uart_tx;

    logic       Clk;
    logic       Rst;
    logic [7:0] P_Data;
    logic       Data_Valid;
    logic [5:0] Prescale;
    logic       Parity_En;
    logic       Parity_Typ;
    logic       TX_OUT;
    logic       Busy;

    int vectors;
    int miscompares;

    logic       bit_q[$];
    int         len_q[$];
    int         p_q[$];
    logic [7:0] byte_q[$];

    uart_tx #(.width(8)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .P_Data     (P_Data),
        .Data_Valid (Data_Valid),
        .Prescale   (Prescale),
        .Parity_En  (Parity_En),
        .Parity_Typ (Parity_Typ),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Called at #1 after an edge with the DUT idle; returns #1 after the
    // acceptance edge, i.e. in the first cycle of the start bit.
    task automatic request(input logic [7:0] d, input logic [5:0] p,
                           input logic pe, input logic pt);
        int pp;
        pp = (p < 6'd2) ? 1 : int'(p);
        P_Data     = d;
        Prescale   = p;
        Parity_En  = pe;
        Parity_Typ = pt;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        bit_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) bit_q.push_back(d[i]);
        if (pe) bit_q.push_back((^d) ^ pt);
        bit_q.push_back(1'b1);
        len_q.push_back(pe ? 11 : 10);
        p_q.push_back(pp);
    endtask

    task automatic flush_sb;
        bit_q.delete();
        len_q.delete();
        p_q.delete();
    endtask

    // Checks one whole frame cycle by cycle; with disturb set, scribbles on
    // every input while the frame is running.
    task automatic check_frame(input string name, input bit disturb);
        int   len;
        int   p;
        logic e;
        logic got_tx;
        logic got_busy;
        bit   bad;
        vectors++;
        if (len_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: scoreboard empty, got 0 frames required 1", name);
            return;
        end
        len = len_q.pop_front();
        p   = p_q.pop_front();
        for (int b = 0; b < len; b++) begin
            e        = bit_q.pop_front();
            bad      = 1'b0;
            got_tx   = e;
            got_busy = 1'b1;
            for (int c = 0; c < p; c++) begin
                if (!bad && (TX_OUT !== e || Busy !== 1'b1)) begin
                    bad      = 1'b1;
                    got_tx   = TX_OUT;
                    got_busy = Busy;
                end
                if (disturb) begin
                    Data_Valid = 1'($urandom_range(0, 1));
                    P_Data     = 8'hFF;
                    Prescale   = 6'($urandom_range(0, 63));
                    Parity_En  = 1'($urandom_range(0, 1));
                    Parity_Typ = 1'($urandom_range(0, 1));
                end
                tick();
            end
            if (b > 0) vectors++;
            if (bad) begin
                miscompares++;
                $display("FAIL %s bit %0d: TX_OUT=%b Busy=%b, required TX_OUT=%b Busy=1",
                         name, b, got_tx, got_busy, e);
            end
        end
        Data_Valid = 1'b0;
        vectors++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s end: TX_OUT=%b Busy=%b, required TX_OUT=1 Busy=0",
                     name, TX_OUT, Busy);
        end
    endtask

    // Receiver model: finds the start bit, samples each bit at its middle.
    task automatic rx_frame(input int p, input logic pe, input logic pt,
                            output logic [7:0] d, output logic perr,
                            output logic ferr, output bit timeout);
        int n;
        d       = '0;
        perr    = 1'b0;
        ferr    = 1'b0;
        timeout = 1'b0;
        n       = 0;
        while (TX_OUT !== 1'b0 && n < 4) begin
            tick();
            n++;
        end
        if (TX_OUT !== 1'b0) begin
            timeout = 1'b1;
            return;
        end
        repeat (p / 2) tick();
        if (TX_OUT !== 1'b0) ferr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            repeat (p) tick();
            d[i] = TX_OUT;
        end
        if (pe) begin
            repeat (p) tick();
            perr = (TX_OUT !== ((^d) ^ pt));
        end
        repeat (p) tick();
        if (TX_OUT !== 1'b1) ferr = 1'b1;
        n = 0;
        while (Busy === 1'b1 && n < 2 * p) begin
            tick();
            n++;
        end
        if (Busy !== 1'b0) timeout = 1'b1;
    endtask

    task automatic test_reset;
        Rst        = 1'b0;
        Data_Valid = 1'b1;
        P_Data     = 8'h00;
        repeat (3) tick();
        vectors++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: TX_OUT=%b Busy=%b, required TX_OUT=1 Busy=0", TX_OUT, Busy);
        end
        Data_Valid = 1'b0;
        Rst        = 1'b1;
        repeat (2) tick();
        vectors++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: TX_OUT=%b Busy=%b, required TX_OUT=1 Busy=0",
                     TX_OUT, Busy);
        end
    endtask

    task automatic test_even_parity;
        request(8'hA5, 6'd8, 1'b1, 1'b0);
        check_frame("even_a5", 1'b0);
        tick();
    endtask

    task automatic test_odd_parity;
        request(8'hA5, 6'd8, 1'b1, 1'b1);
        check_frame("odd_a5", 1'b0);
        tick();
        request(8'h07, 6'd3, 1'b1, 1'b1);
        check_frame("odd_07", 1'b0);
        tick();
    endtask

    task automatic test_parity_disabled;
        request(8'h00, 6'd16, 1'b0, 1'b0);
        check_frame("nopar_00", 1'b0);
        tick();
    endtask

    task automatic test_min_prescale;
        request(8'h5A, 6'd0, 1'b1, 1'b1);
        check_frame("prescale0", 1'b0);
        tick();
        request(8'hC3, 6'd1, 1'b0, 1'b0);
        check_frame("prescale1", 1'b0);
        tick();
    endtask

    task automatic test_request_during_frame;
        request(8'h3C, 6'd5, 1'b1, 1'b0);
        check_frame("disturbed", 1'b1);
        request(8'hFF, 6'd5, 1'b1, 1'b0);
        check_frame("after_disturb_ff", 1'b0);
        tick();
    endtask

    // Each request lands in the first idle cycle after the previous frame.
    task automatic test_back_to_back;
        request(8'h12, 6'd2, 1'b1, 1'b0);
        check_frame("b2b_0", 1'b0);
        request(8'h34, 6'd3, 1'b0, 1'b1);
        check_frame("b2b_1", 1'b0);
        request(8'hE1, 6'd63, 1'b1, 1'b1);
        check_frame("b2b_2", 1'b0);
        tick();
    endtask

    task automatic test_reset_mid_frame;
        request(8'h3C, 6'd8, 1'b1, 1'b0);
        flush_sb();
        repeat (8 + 3 * 8 + 2) tick();
        Rst = 1'b0;
        tick();
        Rst = 1'b1;
        vectors++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_frame: TX_OUT=%b Busy=%b, required TX_OUT=1 Busy=0",
                     TX_OUT, Busy);
        end
        repeat (3) tick();
        vectors++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_abort: TX_OUT=%b Busy=%b, required TX_OUT=1 Busy=0",
                     TX_OUT, Busy);
        end
        request(8'h96, 6'd4, 1'b1, 1'b1);
        check_frame("clean_after_abort", 1'b0);
        tick();
    endtask

    task automatic test_loopback;
        logic [7:0] d;
        logic [7:0] got;
        logic [7:0] want;
        logic       pt;
        logic       perr;
        logic       ferr;
        bit         timeout;
        for (int k = 0; k < 8; k++) begin
            d  = 8'($urandom_range(0, 255));
            pt = 1'(k % 2);
            byte_q.push_back(d);
            request(d, 6'd32, 1'b1, pt);
            flush_sb();
            rx_frame(32, 1'b1, pt, got, perr, ferr, timeout);
            want = byte_q.pop_front();
            vectors++;
            if (timeout || got !== want) begin
                miscompares++;
                $display("FAIL loopback_data %0d: got %h timeout=%0d, required %h",
                         k, got, timeout, want);
            end
            vectors++;
            if (perr !== 1'b0 || ferr !== 1'b0) begin
                miscompares++;
                $display("FAIL loopback_err %0d: parity_err=%b framing_err=%b, required 0 0",
                         k, perr, ferr);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Rst         = 1'b0;
        Data_Valid  = 1'b0;
        P_Data      = '0;
        Prescale    = 6'd8;
        Parity_En   = 1'b0;
        Parity_Typ  = 1'b0;
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_parity_disabled();
        test_min_prescale();
        test_request_during_frame();
        test_back_to_back();
        test_reset_mid_frame();
        test_loopback();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
